// File: rtl/peek_pkg.sv
// Shared definitions for the peek capture path: data widths, match-mode
// encodings and the capture controller state encoding.
package peek_pkg;

  localparam int ET_W   = 16;
  localparam int VETO_W = 16;

  localparam logic [1:0] MODE_ET   = 2'b00;
  localparam logic [1:0] MODE_VETO = 2'b01;
  localparam logic [1:0] MODE_AND  = 2'b10;
  localparam logic [1:0] MODE_OR   = 2'b11;

  typedef enum logic [1:0] {
    PS_IDLE    = 2'd0,
    PS_ARMED   = 2'd1,
    PS_CAPTURE = 2'd2,
    PS_READOUT = 2'd3
  } peek_state_e;

  // Plain constants so the state register can stay a bare logic vector.
  localparam logic [1:0] ST_IDLE    = PS_IDLE;
  localparam logic [1:0] ST_ARMED   = PS_ARMED;
  localparam logic [1:0] ST_CAPTURE = PS_CAPTURE;
  localparam logic [1:0] ST_READOUT = PS_READOUT;

endpackage

// File: rtl/peek_trig_match.sv
// Combinational trigger match of one ET/veto sample against a mode and an
// ET threshold; shared by the trigger blocks of the peek path.
module peek_trig_match
  import peek_pkg::*;
(
  input  logic [1:0]        mode,
  input  logic [ET_W-1:0]   thre,
  input  logic [ET_W:0]     in_et,
  input  logic [VETO_W-1:0] in_veto,
  output logic              match
);

  logic peak_hit;
  logic veto_hit;

  // Threshold compare is strict: an ET sum equal to thre does not fire.
  assign peak_hit = in_et[ET_W] && (in_et[ET_W-1:0] > thre);
  assign veto_hit = |in_veto;

  always_comb begin
    match = 1'b0;
    case (mode)
      MODE_ET:   match = peak_hit;
      MODE_VETO: match = veto_hit;
      MODE_AND:  match = peak_hit && veto_hit;
      MODE_OR:   match = peak_hit || veto_hit;
      default:   match = 1'b0;
    endcase
  end

endmodule

// File: rtl/peek_capture_ctrl.sv
// Single-shot raw-pulse capture sequencer: arm, wait for a match, record DEPTH
// samples, drain them over a valid/ready port. PEEK_TIMESTAMP_EN adds trig_ts.
module peek_capture_ctrl
  import peek_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TO_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cfg_mode,
  input  logic [ET_W-1:0]   cfg_thre,
  input  logic [TO_W-1:0]   cfg_timeout,
  input  logic              arm,
  input  logic              abort,
  input  logic [ET_W:0]     in_et,
  input  logic [VETO_W-1:0] in_veto,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ET_W-1:0]   rd_et,
  output logic [VETO_W-1:0] rd_veto,
  output logic              rd_last,
  output logic              busy,
  output logic              armed,
  output logic              timeout_pulse,
  output logic [1:0]        dbg_state
`ifdef PEEK_TIMESTAMP_EN
  ,
  output logic [31:0]       trig_ts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [1:0]        state;
  logic [1:0]        sh_mode;
  logic [ET_W-1:0]   sh_thre;
  logic [TO_W-1:0]   sh_timeout;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_cnt_inc;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_ptr_inc;
  logic [ET_W-1:0]   cap_et   [DEPTH];
  logic [VETO_W-1:0] cap_veto [DEPTH];
  logic              match;
  logic              trig;
  logic              to_hit;
  logic              xfer;
  logic              wr_en;

  peek_trig_match u_match (
    .mode    (sh_mode),
    .thre    (sh_thre),
    .in_et   (in_et),
    .in_veto (in_veto),
    .match   (match)
  );

  assign to_cnt_inc = to_cnt + TO_W'(1);
  assign rd_ptr_inc = rd_ptr + AW'(1);

  // A match beats a coinciding timeout; abort beats both.
  assign trig   = (state == ST_ARMED) && match && !abort;
  assign to_hit = (state == ST_ARMED) && !match && !abort &&
                  (sh_timeout != '0) && (to_cnt_inc == sh_timeout);

  // Readout handshake: a word transfers on a cycle where rd_valid and
  // rd_ready are both high; while rd_valid=1 and rd_ready=0 the word holds.
  assign xfer          = rd_valid && rd_ready;
  assign rd_last       = rd_valid && (rd_ptr == LAST_IDX);
  assign timeout_pulse = to_hit;
  assign busy          = (state != ST_IDLE);
  assign armed         = (state == ST_ARMED);
  assign dbg_state     = state;
  assign wr_en         = trig || (state == ST_CAPTURE);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      cap_et[wr_ptr]   <= in_et[ET_W-1:0];
      cap_veto[wr_ptr] <= in_veto;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sh_mode    <= '0;
      sh_thre    <= '0;
      sh_timeout <= '0;
      to_cnt     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid   <= 1'b0;
      rd_et      <= '0;
      rd_veto    <= '0;
    end else if (abort) begin
      state    <= ST_IDLE;
      to_cnt   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_et    <= '0;
      rd_veto  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            sh_mode    <= cfg_mode;
            sh_thre    <= cfg_thre;
            sh_timeout <= cfg_timeout;
            to_cnt     <= '0;
            wr_ptr     <= '0;
            state      <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (match) begin
            wr_ptr <= AW'(1);
            state  <= ST_CAPTURE;
          end else if (to_hit) begin
            to_cnt <= '0;
            state  <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt_inc;
          end
        end
        ST_CAPTURE: begin
          if (wr_ptr == LAST_IDX) begin
            // Entry 0 was written long ago, so it can be presented right away.
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b1;
            rd_et    <= cap_et[0];
            rd_veto  <= cap_veto[0];
            state    <= ST_READOUT;
          end else begin
            wr_ptr <= wr_ptr + AW'(1);
          end
        end
        ST_READOUT: begin
          if (xfer) begin
            if (rd_ptr == LAST_IDX) begin
              rd_ptr   <= '0;
              rd_valid <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              rd_ptr  <= rd_ptr_inc;
              rd_et   <= cap_et[rd_ptr_inc];
              rd_veto <= cap_veto[rd_ptr_inc];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PEEK_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt  <= '0;
      trig_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (trig) trig_ts <= ts_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_peek_capture_ctrl.sv
// Self-checking bench for peek_capture_ctrl: match-table vectors, directed
// corner sequences and randomized arm/capture/readout runs.
module tb_peek_capture_ctrl;
  import peek_pkg::*;

  localparam int DEPTH = 8;
  localparam int TO_W  = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      cfg_mode = '0;
  logic [15:0]     cfg_thre = '0;
  logic [TO_W-1:0] cfg_timeout = '0;
  logic            arm = 1'b0;
  logic            abort = 1'b0;
  logic [16:0]     in_et = '0;
  logic [15:0]     in_veto = '0;
  logic            rd_valid;
  logic            rd_ready = 1'b0;
  logic [15:0]     rd_et;
  logic [15:0]     rd_veto;
  logic            rd_last;
  logic            busy;
  logic            armed;
  logic            timeout_pulse;
  logic [1:0]      dbg_state;
`ifdef PEEK_TIMESTAMP_EN
  logic [31:0]     trig_ts;
  logic [31:0]     ts_model;
  logic [31:0]     exp_ts = '0;
`endif

  always #5 clk = ~clk;

  peek_capture_ctrl #(.DEPTH(DEPTH), .TO_W(TO_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_mode      (cfg_mode),
    .cfg_thre      (cfg_thre),
    .cfg_timeout   (cfg_timeout),
    .arm           (arm),
    .abort         (abort),
    .in_et         (in_et),
    .in_veto       (in_veto),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_et         (rd_et),
    .rd_veto       (rd_veto),
    .rd_last       (rd_last),
    .busy          (busy),
    .armed         (armed),
    .timeout_pulse (timeout_pulse),
    .dbg_state     (dbg_state)
`ifdef PEEK_TIMESTAMP_EN
    ,
    .trig_ts       (trig_ts)
`endif
  );

`ifdef PEEK_TIMESTAMP_EN
  // Cycles elapsed since reset release: the expected timestamp source.
  always @(posedge clk) begin
    if (reset) ts_model <= '0;
    else       ts_model <= ts_model + 32'd1;
  end
`endif

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] thre;
    logic [16:0] et;
    logic [15:0] veto;
    logic        exp_m;
  } vec_t;
  vec_t vecs[12];

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic ref_match(input logic [1:0] m, input logic [15:0] t,
                                     input logic [16:0] e, input logic [15:0] v);
    bit pk;
    bit vt;
    pk = (e[16] == 1'b1) && (int'(e[15:0]) > int'(t));
    vt = (int'(v) != 0);
    case (m)
      2'd0:    return pk;
      2'd1:    return vt;
      2'd2:    return pk && vt;
      default: return pk || vt;
    endcase
  endfunction

  task automatic arm_cfg(input logic [1:0] m, input logic [15:0] t, input logic [TO_W-1:0] to);
    cfg_mode = m;
    cfg_thre = t;
    cfg_timeout = to;
    in_et = '0;
    in_veto = '0;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    // Scramble config pins: only the values latched at arm may matter.
    cfg_mode = 2'($urandom);
    cfg_thre = 16'($urandom);
    cfg_timeout = TO_W'($urandom);
  endtask

  task automatic trigger(input logic [16:0] e, input logic [15:0] v);
    in_et = e;
    in_veto = v;
    exp_q.push_back({e[15:0], v});
`ifdef PEEK_TIMESTAMP_EN
    exp_ts = ts_model;
`endif
    cyc();
    chk("capture_state", dbg_state, 2'd2);
  endtask

  task automatic fill_after_trigger();
    logic [15:0] e;
    logic [15:0] v;
    for (int i = 1; i < DEPTH; i++) begin
      e = 16'($urandom);
      v = 16'($urandom);
      in_et = {1'($urandom), e};
      in_veto = v;
      exp_q.push_back({e, v});
      cyc();
    end
    in_et = '0;
    in_veto = '0;
`ifdef PEEK_TIMESTAMP_EN
    chk("trig_ts", trig_ts, exp_ts);
`endif
  endtask

  task automatic drain(input int pat);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      case (pat)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (k % 4 == 0) || (k % 4 == 3);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      arm = ($urandom_range(0, 7) == 0);
      in_et = 17'($urandom);
      in_veto = 16'($urandom);
      #1;
      chk("rd_valid", rd_valid, 1);
      chk("rd_word", {rd_et, rd_veto}, exp_q[0]);
      chk("rd_last", rd_last, exp_q.size() == 1);
      if (rd_ready) void'(exp_q.pop_front());
      cyc();
      k++;
    end
    arm = 1'b0;
    rd_ready = 1'b0;
    in_et = '0;
    in_veto = '0;
    if (exp_q.size() > 0) begin
      chk("drain_budget", exp_q.size(), 0);
      exp_q.delete();
    end
    chk("post_rd_valid", rd_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    logic [1:0]  m;
    logic [15:0] t;
    logic [15:0] to;
    logic [16:0] e;
    logic [15:0] v;
    logic        mt;
    logic        exp_to;
    logic        any_pulse;
    int          n;
    bit          done;

    vecs[0]  = '{2'd0, 16'd100,   {1'b1, 16'd100},   16'h0000, 1'b0};
    vecs[1]  = '{2'd0, 16'd100,   {1'b1, 16'd101},   16'h0000, 1'b1};
    vecs[2]  = '{2'd0, 16'd100,   {1'b0, 16'd500},   16'h0000, 1'b0};
    vecs[3]  = '{2'd0, 16'hffff,  {1'b1, 16'hffff},  16'h0000, 1'b0};
    vecs[4]  = '{2'd1, 16'd0,     {1'b1, 16'hffff},  16'h0000, 1'b0};
    vecs[5]  = '{2'd1, 16'hffff,  {1'b0, 16'h0000},  16'h0001, 1'b1};
    vecs[6]  = '{2'd2, 16'd50,    {1'b1, 16'd200},   16'h0000, 1'b0};
    vecs[7]  = '{2'd2, 16'd50,    {1'b1, 16'd200},   16'h0004, 1'b1};
    vecs[8]  = '{2'd2, 16'd50,    {1'b0, 16'd200},   16'h0004, 1'b0};
    vecs[9]  = '{2'd3, 16'd50,    {1'b0, 16'd0},     16'h8000, 1'b1};
    vecs[10] = '{2'd3, 16'd50,    {1'b1, 16'd51},    16'h0000, 1'b1};
    vecs[11] = '{2'd3, 16'd50,    {1'b1, 16'd50},    16'h0000, 1'b0};

    // Reset state
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_busy", busy, 0);
    chk("rst_armed", armed, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_word", {rd_et, rd_veto}, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_timeout_pulse", timeout_pulse, 0);
`ifdef PEEK_TIMESTAMP_EN
    chk("rst_trig_ts", trig_ts, 0);
`endif

    // Match table: one sample while armed, then abort back to idle
    for (int i = 0; i < 12; i++) begin
      arm_cfg(vecs[i].mode, vecs[i].thre, '0);
      chk("tbl_armed_after_arm", armed, 1);
      in_et = vecs[i].et;
      in_veto = vecs[i].veto;
      cyc();
      chk("tbl_still_armed", armed, !vecs[i].exp_m);
      chk("tbl_busy", busy, 1);
      in_et = '0;
      in_veto = '0;
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("tbl_abort_idle", busy, 0);
    end

    // Mode 00, thre=100: 100 does not fire, 101 does
    arm_cfg(2'd0, 16'd100, '0);
    in_et = {1'b1, 16'd100};
    in_veto = 16'h0;
    cyc();
    chk("m0_no_trig_at_thre", armed, 1);
    trigger({1'b1, 16'd101}, 16'($urandom));
    fill_after_trigger();
    chk("m0_readout_valid", rd_valid, 1);
    drain(0);

    // Mode 10, thre=50, with 1,0,0,1 backpressure on readout
    arm_cfg(2'd2, 16'd50, '0);
    in_et = {1'b1, 16'd200};
    in_veto = 16'h0;
    cyc();
    chk("m2_no_trig_without_veto", armed, 1);
    trigger({1'b1, 16'd200}, 16'h0004);
    fill_after_trigger();
    drain(1);

    // Mode 11, timeout=20 on idle inputs
    arm_cfg(2'd3, 16'd0, 16'd20);
    for (int i = 1; i <= 20; i++) begin
      in_et = '0;
      in_veto = '0;
      #1;
      chk("to20_armed", armed, 1);
      chk("to20_pulse", timeout_pulse, i == 20);
      cyc();
    end
    chk("to20_idle", busy, 0);
    chk("to20_pulse_gone", timeout_pulse, 0);

    // timeout=0: stays armed for 1000 cycles
    arm_cfg(2'd3, 16'd0, '0);
    any_pulse = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (timeout_pulse) any_pulse = 1'b1;
      cyc();
    end
    chk("to0_no_pulse", any_pulse, 0);
    chk("to0_still_armed", armed, 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;

    // Abort at wr_ptr=3: aborted capture never reaches readout
    arm_cfg(2'd1, 16'd0, '0);
    trigger({1'b0, 16'd9}, 16'h0001);
    exp_q.delete();
    repeat (2) begin
      in_et = 17'($urandom);
      in_veto = 16'($urandom);
      cyc();
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_idle", busy, 0);
    for (int i = 0; i < 12; i++) begin
      in_et = 17'($urandom);
      in_veto = 16'($urandom);
      #1;
      chk("abort_no_valid", rd_valid, 0);
      cyc();
    end
`ifdef PEEK_TIMESTAMP_EN
    chk("abort_keeps_trig_ts", trig_ts, exp_ts);
`endif
    // arm together with abort: abort wins
    cfg_mode = 2'd1;
    arm = 1'b1;
    abort = 1'b1;
    in_veto = 16'h0001;
    cyc();
    arm = 1'b0;
    abort = 1'b0;
    chk("arm_abort_idle", busy, 0);
    arm_cfg(2'd1, 16'd0, '0);
    trigger({1'b1, 16'd77}, 16'h0007);
    fill_after_trigger();
    drain(0);

    // Randomized runs against the reference model
    for (int it = 0; it < 40; it++) begin
      m = 2'($urandom_range(0, 3));
      t = 16'($urandom_range(0, 65535));
      to = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
      arm_cfg(m, t, to);
      n = 0;
      done = 0;
      while (!done && n < 300) begin
        e = {1'($urandom_range(0, 1)), 16'($urandom)};
        v = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(1, 65535)) : 16'd0;
        in_et = e;
        in_veto = v;
        n++;
        mt = ref_match(m, t, e, v);
        exp_to = !mt && (to != 0) && (n == int'(to));
        #1;
        chk("rnd_armed", armed, 1);
        chk("rnd_timeout_pulse", timeout_pulse, exp_to);
        if (mt) begin
          exp_q.push_back({e[15:0], v});
`ifdef PEEK_TIMESTAMP_EN
          exp_ts = ts_model;
`endif
          cyc();
          chk("rnd_capture_state", dbg_state, 2'd2);
          fill_after_trigger();
          drain(2);
          done = 1;
        end else if (exp_to) begin
          cyc();
          chk("rnd_timeout_idle", busy, 0);
          done = 1;
        end else begin
          cyc();
        end
      end
      if (!done) begin
        abort = 1'b1;
        cyc();
        abort = 1'b0;
      end
    end

    // Reset during readout
    arm_cfg(2'd0, 16'd0, '0);
    trigger({1'b1, 16'd5}, 16'h0000);
    fill_after_trigger();
    rd_ready = 1'b1;
    cyc();
    rd_ready = 1'b0;
    exp_q.delete();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rrst_state", dbg_state, 2'd0);
    chk("rrst_busy", busy, 0);
    chk("rrst_armed", armed, 0);
    chk("rrst_rd_valid", rd_valid, 0);
    chk("rrst_rd_word", {rd_et, rd_veto}, 0);
    chk("rrst_rd_last", rd_last, 0);
    chk("rrst_timeout_pulse", timeout_pulse, 0);
`ifdef PEEK_TIMESTAMP_EN
    chk("rrst_trig_ts", trig_ts, 0);
`endif
    arm_cfg(2'd3, 16'd10, '0);
    trigger({1'b1, 16'd11}, 16'h0000);
    fill_after_trigger();
    drain(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/peek_capture_ctrl.md
Name: peek_capture_ctrl

Overview:
Sequences single-shot raw-pulse capture for the Top CDT trigger path. Software arms it with a match mode and an ET threshold. The block waits for a matching ET/veto sample, records the triggering sample plus the following DEPTH-1 samples into a local buffer, then drains them over a valid/ready readout port. It provides the arm/timeout/abort control that the free-running peek logic lacks, and sits between the ET/veto sum stage and the DAQ readout.

Parameters:
DEPTH, 8, number of captured samples (power of 2, 2..64)
TO_W, 16, width of the armed-timeout counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_mode  in  2  match mode: 00 ET peak>thre; 01 veto>0; 10 ET peak>thre AND veto>0; 11 ET peak OR veto>0
cfg_thre  in  16  ET threshold (strict greater-than)
cfg_timeout  in  TO_W  max cycles armed; 0 = never time out
arm  in  1  start request (one-cycle pulse)
abort  in  1  cancel any operation
in_et  in  17  [16]=peak flag, [15:0]=ET sum
in_veto  in  16  veto word
rd_valid  out  1  readout word available
rd_ready  in  1  consumer accepts word
rd_et  out  16  captured ET
rd_veto  out  16  captured veto
rd_last  out  1  final word of capture
busy  out  1  state != IDLE
armed  out  1  state == ARMED
timeout_pulse  out  1  one-cycle pulse on timeout
trig_ts  out  32  (PEEK_TIMESTAMP_EN only) free-running cycle count at trigger

Behaviour:
- Reset: state=IDLE; all outputs 0; write/read pointers and timeout counter 0. Buffer contents are don't-care.
- States: IDLE, ARMED, CAPTURE, READOUT.
- IDLE: an arm pulse latches cfg_mode, cfg_thre and cfg_timeout into shadow registers, clears the timeout counter and enters ARMED next cycle. Config changes after arm have no effect until the next arm.
- ARMED: match is evaluated combinationally on the current in_et/in_veto using the shadow config.
  - Peak condition: in_et[16]=1 and in_et[15:0] > thre. Veto condition: in_veto != 0.
  - On match: the sample is written to buf[0], wr_ptr becomes 1, state moves to CAPTURE.
  - Otherwise the counter increments. When the counter equals a nonzero timeout, state returns to IDLE and timeout_pulse is asserted for 1 cycle. Match in that same cycle wins over timeout.
- CAPTURE: writes in_et[15:0]/in_veto unconditionally every cycle to buf[wr_ptr], incrementing wr_ptr. After writing index DEPTH-1, moves to READOUT. Total capture is DEPTH consecutive cycles, the trigger cycle included.
- READOUT: rd_valid is high from the first cycle in READOUT. The word at rd_ptr is presented registered and held stable while rd_valid=1 and rd_ready=0.
  - Transfer occurs when rd_valid and rd_ready are both 1; rd_ptr then increments.
  - rd_last=1 with index DEPTH-1. A transfer on rd_last returns to IDLE, with rd_valid=0 in the next cycle.
- Arm outside IDLE: ignored, no queuing.
- Abort: from any state, goes to IDLE next cycle, clears rd_valid and pointers, and discards the buffer. Abort together with arm in IDLE: abort wins and the block stays IDLE.
- reset overrides abort, and abort overrides all other events.
- Pointers are log2(DEPTH) bits wide plus a terminal compare; no wrap-around reuse.

Optional Feature:
PEEK_TIMESTAMP_EN:
- Defined: a 32-bit free-running counter (reset to 0, wraps modulo 2^32) is sampled into trig_ts in the match cycle. trig_ts holds until the next trigger; it is 0 after reset and unchanged by abort.
- Undefined: the trig_ts port and counter are absent.

Decomposition:
- Package peek_pkg holds:
  - mode encodings MODE_ET=2'b00, MODE_VETO=2'b01, MODE_AND=2'b10, MODE_OR=2'b11
  - state enum typedef
  - ET_W=16, VETO_W=16
- Sub-module peek_trig_match: purely combinational match of (mode, thre, in_et, in_veto) to a 1-bit match. Reused by other trigger blocks.
- The buffer is an inline register array; no separate module.

Test Plan:
- Mode 00, thre=100: arm, drive in_et={1,16'd100} then {1,16'd101}. No trigger on 100; trigger on 101. DEPTH=8 words read back with rd_et[0]=101 and rd_last on the 8th word.
- Mode 10, thre=50: in_et={1,200} with veto=0 gives no trigger; the next cycle, in_et={1,200} with veto=16'h0004 triggers; buf[0] = (200, 4).
- Mode 11, timeout=20, idle inputs: timeout_pulse at exactly the 20th armed cycle, then IDLE with busy=0. Repeat with timeout=0: stays ARMED for 1000 cycles.
- Readout backpressure: rd_ready toggling 1,0,0,1: data stable during stalls, and exactly 8 transfers in order.
- Abort mid-CAPTURE (at wr_ptr=3), then a re-arm and trigger: rd_valid never asserted for the aborted capture; the new capture reads correct data. Also check that arm+abort in the same cycle stays IDLE.
- reset asserted during READOUT: next cycle all outputs 0 and state IDLE; with PEEK_TIMESTAMP_EN, trig_ts=0.
